q9_seq_detector: RTL and testbench

Serial bit-pattern detector: a Moore state machine samples one input bit per clock and raises a one-cycle `detected` flag whenever the most recent bits equal a fixed pattern. It sits on a serial data line behind any synchronizer and feeds control logic or an interrupt/event counter. The pattern and its length are parameters; the default detects three consecutive zeros (`000`).

---
 rtl/q9_seq_detector.sv | 108 ++++++++++
 tb/tb_q9_seq_detector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/q9_seq_detector.sv
// q9_seq_detector
//
// Serial bit-pattern detector. A Moore FSM consumes one bit of din per rising clk edge and
// raises detected for one cycle each time the most recently received bits equal PATTERN
// (MSB received first). The state is the length of the matched pattern prefix (S0 = idle)
// plus a MATCH state. Mismatch transitions follow the KMP failure rule and are computed at
// elaboration time from PATTERN.
//
// Parameters:
//   PAT_LEN   pattern length in bits, legal range 2..8 (default 3)
//   PATTERN   pattern bits, MSB received first (default 3'b000)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset; forces idle and detected = 0
//   din       in   serial data bit, sampled every rising clk edge
//   detected  out  high for exactly one cycle per match (decoded from the state register)
//
// Configuration macro:
//   Q9_OVERLAP_EN  defined: overlapping matches (MATCH behaves as a full-length prefix).
//                  undefined: non-overlapping matches (MATCH behaves as idle).

module q9_seq_detector #(
  parameter int unsigned           PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0]    PATTERN = 3'b000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic detected
);

  localparam int unsigned SW = $clog2(PAT_LEN + 1);

  // Intermediate states S1..S(PAT_LEN-1) are encoded as their prefix length k.
  typedef enum logic [SW-1:0] {
    S0    = '0,
    MATCH = SW'(PAT_LEN)
  } state_t;

`ifdef Q9_OVERLAP_EN
  // Row PAT_LEN holds the transitions out of MATCH when overlaps are allowed.
  localparam int unsigned TblLen = PAT_LEN + 1;
`else
  localparam int unsigned TblLen = PAT_LEN;
`endif

  // Longest pattern prefix that is a suffix of (first k pattern bits followed by b).
  // A result of PAT_LEN means the full pattern has just been received.
  function automatic int unsigned next_len(input int unsigned k, input int unsigned b);
    int unsigned p;
    int unsigned s;
    int unsigned len;
    int unsigned best;
    p    = 32'(PATTERN);
    // Received bits as an integer, most recent bit in the LSB.
    s    = ((p >> (PAT_LEN - k)) << 1) | (b & 32'd1);
    len  = k + 1;
    best = 0;
    for (int unsigned l = 1; l <= PAT_LEN; l++) begin
      if (l <= len && (s & ((32'd1 << l) - 32'd1)) == (p >> (PAT_LEN - l))) begin
        best = l;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] nxt0 [TblLen];
  logic [SW-1:0] nxt1 [TblLen];

  for (genvar k = 0; k < TblLen; k++) begin : g_tbl
    localparam int unsigned N0 = next_len(k, 0);
    localparam int unsigned N1 = next_len(k, 1);
    assign nxt0[k] = N0[SW-1:0];
    assign nxt1[k] = N1[SW-1:0];
  end

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // Unreachable encodings fall through to idle.
    state_d = S0;
    if (state_q == MATCH) begin
`ifdef Q9_OVERLAP_EN
      state_d = state_t'(din ? nxt1[PAT_LEN] : nxt0[PAT_LEN]);
`else
      state_d = state_t'(din ? nxt1[0] : nxt0[0]);
`endif
    end else begin
      for (int k = 0; k < PAT_LEN; k++) begin
        if (int'(state_q) == k) begin
          state_d = state_t'(din ? nxt1[k] : nxt0[k]);
        end
      end
    end
  end

  assign detected = (state_q == MATCH);

endmodule

// File: tb/tb_q9_seq_detector.sv
// Bench for q9_seq_detector: one default instance (pattern 000) and one with PAT_LEN=4,
// PATTERN=4'b1011, both driven together. Expected flags come from a sliding-window model:
// a match is the last PAT_LEN received bits equalling the pattern, counting only bits
// received since reset (and, without overlap, since the previous match).

module tb_q9_seq_detector;

  logic clk = 1'b0;
  logic rst;
  logic din0, din1;
  logic det0, det1;

  always #5 clk = ~clk;

  q9_seq_detector u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .din      (din0),
    .detected (det0)
  );

  q9_seq_detector #(
    .PAT_LEN (4),
    .PATTERN (4'b1011)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .din      (din1),
    .detected (det1)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  h0, h1;
  int unsigned c0, c1;
  logic        e0, e1;

  task automatic model_step(input logic b, input int unsigned len, input logic [7:0] pat,
                            inout logic [7:0] h, inout int unsigned cnt, output logic hit);
    logic [7:0] mask;
    mask = 8'((9'd1 << len) - 9'd1);
    h    = {h[6:0], b};
    if (cnt < 8) cnt++;
    hit = (cnt >= len) && ((h & mask) == (pat & mask));
`ifndef Q9_OVERLAP_EN
    if (hit) cnt = 0;
`endif
  endtask

  task automatic model_reset();
    h0 = '0;
    h1 = '0;
    c0 = 0;
    c1 = 0;
  endtask

  // Drive one bit into each instance, advance past the sampling edge, update the model.
  task automatic apply(input logic b0, input logic b1);
    din0 = b0;
    din1 = b1;
    @(posedge clk);
    #1;
    model_step(b0, 3, 8'h00, h0, c0, e0);
    model_step(b1, 4, 8'h0b, h1, c1, e1);
  endtask

  // Mid-cycle reset pulse that does not coincide with a clock edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [2:0] s0;
    logic [2:0] s1;
    rst  = 1'b0;
    din0 = 1'b0;
    din1 = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (det0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold dut0: detected=%b expected=0", det0);
    end
    vectors++;
    if (det1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold dut1: detected=%b expected=0", det1);
    end
    rst = 1'b0;
    model_reset();
    // Reach S2 on the 000 detector, then reset asynchronously.
    apply(1'b0, 1'b1);
    apply(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (det0 !== 1'b0 || det1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async_s2: detected=%b%b expected=00", det0, det1);
    end
    rst = 1'b0;
    model_reset();
    // History must be gone: two zeros alone must not complete the pattern.
    s0 = 3'b000;
    s1 = 3'b111;
    for (int i = 2; i >= 0; i--) begin
      apply(s0[i], s1[i]);
      vectors++;
      if (det0 !== e0) begin
        miscompares++;
        $display("FAIL reset_restart dut0 bit %0d: detected=%b expected=%b", 3 - i, det0, e0);
      end
    end
    // detected is now high; reset must clear it without a clock edge.
    rst = 1'b1;
    #1;
    vectors++;
    if (det0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async_match dut0: detected=%b expected=0", det0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [3:0] s0;
    logic [3:0] s1;
    pulse_reset();
    s0 = 4'b0001;
    s1 = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      apply(s0[i], s1[i]);
      vectors++;
      if (det0 !== e0) begin
        miscompares++;
        $display("FAIL basic dut0 bit %0d: detected=%b expected=%b", 4 - i, det0, e0);
      end
      vectors++;
      if (det1 !== e1) begin
        miscompares++;
        $display("FAIL basic dut1 bit %0d: detected=%b expected=%b", 4 - i, det1, e1);
      end
    end
  endtask

  task automatic test_break_restart();
    logic [8:0] s0;
    logic [8:0] s1;
    pulse_reset();
    s0 = 9'b001000111;
    s1 = 9'b101011011;
    for (int i = 8; i >= 0; i--) begin
      apply(s0[i], s1[i]);
      vectors++;
      if (det0 !== e0) begin
        miscompares++;
        $display("FAIL break_restart dut0 bit %0d: detected=%b expected=%b", 9 - i, det0, e0);
      end
      vectors++;
      if (det1 !== e1) begin
        miscompares++;
        $display("FAIL break_restart dut1 bit %0d: detected=%b expected=%b", 9 - i, det1, e1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] s0;
    logic [9:0] s1;
    pulse_reset();
    s0 = 10'b0000001000;
    s1 = 10'b1011011011;
    for (int i = 9; i >= 0; i--) begin
      apply(s0[i], s1[i]);
      vectors++;
      if (det0 !== e0) begin
        miscompares++;
        $display("FAIL back_to_back dut0 bit %0d: detected=%b expected=%b", 10 - i, det0, e0);
      end
      vectors++;
      if (det1 !== e1) begin
        miscompares++;
        $display("FAIL back_to_back dut1 bit %0d: detected=%b expected=%b", 10 - i, det1, e1);
      end
    end
  endtask

  task automatic test_random();
    logic b0, b1;
    pulse_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (det0 !== 1'b0 || det1 !== 1'b0) begin
          miscompares++;
          $display("FAIL random_reset cycle %0d: detected=%b%b expected=00", n, det0, det1);
        end
        rst = 1'b0;
        model_reset();
      end
      b0 = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      b1 = 1'($urandom_range(0, 1));
      apply(b0, b1);
      vectors++;
      if (det0 !== e0) begin
        miscompares++;
        $display("FAIL random dut0 cycle %0d: detected=%b expected=%b", n, det0, e0);
      end
      vectors++;
      if (det1 !== e1) begin
        miscompares++;
        $display("FAIL random dut1 cycle %0d: detected=%b expected=%b", n, det1, e1);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_break_restart();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
